// File: rtl/can_tx_demux_n.sv
// can_tx_demux_n: registered 1-to-N demultiplexer for a CAN TX bit stream.
// One channel carries tx_i and every other channel is held recessive (1).
// A channel change waits until the bus has been recessive for IDLE_CYC
// cycles, so a frame in flight is never cut. A dominant input that lasts
// DOM_MAX cycles forces all outputs recessive and raises fault until it is
// cleared.
//
// Handshake: sel_req is a single-cycle strobe with no ready. A valid
// request (sel_i < N_CH) is acted on according to the current state.
// An invalid request is dropped and answered by a one-cycle sel_err pulse
// on the following cycle.
module can_tx_demux_n #(
  parameter int unsigned N_CH     = 32,
  parameter int unsigned SEL_W    = 5,
  parameter int unsigned IDLE_CYC = 11,
  parameter int unsigned DOM_MAX  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [SEL_W-1:0] sel_i,
  input  logic             sel_req,
  input  logic             tx_i,
  input  logic             fault_clr,
  output logic [N_CH-1:0]  tx_o,
  output logic [SEL_W-1:0] active_sel,
  output logic             busy,
  output logic             sel_err,
  output logic             fault,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [7:0]  IDLE_LIM = 8'(IDLE_CYC);
  localparam logic [15:0] DOM_LIM  = 16'(DOM_MAX);

  state_t           state_q, state_d;
  logic [7:0]       rcnt_q, rcnt_d;
  logic [15:0]      dcnt_q, dcnt_d;
  logic [SEL_W-1:0] active_sel_q, active_sel_d;
  logic [SEL_W-1:0] pending_q, pending_d;
  logic [N_CH-1:0]  tx_o_q, tx_o_d;
  logic             sel_err_q, sel_err_d;

  logic sel_valid;
  logic trip;
  logic bus_idle;
  logic drive;

  // Run-length counters, next state, select registers and output image.
  always_comb begin
    sel_valid    = sel_req && (32'(sel_i) < N_CH);
    sel_err_d    = sel_req && !(32'(sel_i) < N_CH);
    trip         = (dcnt_q == DOM_LIM);
    bus_idle     = (rcnt_q == IDLE_LIM);
    rcnt_d       = tx_i ? ((rcnt_q == IDLE_LIM) ? rcnt_q : rcnt_q + 8'd1) : 8'd0;
    dcnt_d       = tx_i ? 16'd0 : ((dcnt_q == DOM_LIM) ? dcnt_q : dcnt_q + 16'd1);
    state_d      = state_q;
    active_sel_d = active_sel_q;
    pending_d    = pending_q;
    drive        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // No traffic is passed here, so a new channel takes effect at once.
        if (sel_valid) active_sel_d = sel_i;
        if (en) state_d = ST_PASS;
      end
      ST_PASS: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else if (trip) begin
          state_d = ST_FAULT;
        end else begin
          drive = 1'b1;
          if (sel_valid && (sel_i != active_sel_q)) begin
            pending_d = sel_i;
            state_d   = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!en) begin
          state_d   = ST_IDLE;
          pending_d = '0;
        end else if (trip) begin
          // The fault wins over a commit in the same cycle: old channel kept.
          state_d   = ST_FAULT;
          pending_d = '0;
        end else if (bus_idle) begin
          // Commit edge: all outputs recessive, new channel driven next cycle.
          active_sel_d = pending_q;
          pending_d    = '0;
          state_d      = ST_PASS;
        end else begin
          drive = 1'b1;
          if (sel_valid) pending_d = sel_i;
        end
      end
      ST_FAULT: begin
        // Leave only once the line is seen recessive while clear is asked.
        if (fault_clr && tx_i) state_d = en ? ST_PASS : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tx_o_d = '1;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (drive && (32'(active_sel_q) == k)) tx_o_d[k] = tx_i;
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      rcnt_q       <= 8'd0;
      dcnt_q       <= 16'd0;
      active_sel_q <= '0;
      pending_q    <= '0;
      tx_o_q       <= '1;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rcnt_q       <= rcnt_d;
      dcnt_q       <= dcnt_d;
      active_sel_q <= active_sel_d;
      pending_q    <= pending_d;
      tx_o_q       <= tx_o_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign tx_o       = tx_o_q;
  assign active_sel = active_sel_q;
  assign busy       = (state_q == ST_WAIT);
  assign fault      = (state_q == ST_FAULT);
  assign sel_err    = sel_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_can_tx_demux_n.sv
// Testbench for can_tx_demux_n (N_CH=32, SEL_W=6, IDLE_CYC=11, DOM_MAX=16).
// A behavioural model tracks run lengths as plain integers and the mode as
// a few flags; every cycle the DUT outputs are compared with it.
module tb_can_tx_demux_n;

  localparam int NCH  = 32;
  localparam int SW   = 6;
  localparam int IDLE = 11;
  localparam int DOM  = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          en = 1'b0;
  logic [SW-1:0] sel_i = '0;
  logic          sel_req = 1'b0;
  logic          tx_i = 1'b1;
  logic          fault_clr = 1'b0;
  logic [NCH-1:0] tx_o;
  logic [SW-1:0] active_sel;
  logic          busy, sel_err, fault;
  logic [1:0]    state_dbg;

  can_tx_demux_n #(.N_CH(NCH), .SEL_W(SW), .IDLE_CYC(IDLE), .DOM_MAX(DOM)) dut (
    .clk(clk), .rst(rst), .en(en), .sel_i(sel_i), .sel_req(sel_req),
    .tx_i(tx_i), .fault_clr(fault_clr), .tx_o(tx_o), .active_sel(active_sel),
    .busy(busy), .sel_err(sel_err), .fault(fault), .state_dbg(state_dbg)
  );

  // scoreboard counters
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h exp=%h", tag, $time, got, exp);
    end
  endtask

  // reference model
  bit             m_off;      // outputs parked, waiting for enable
  bit             m_fault;
  bit             m_wait;
  int             m_act;
  int             m_pend;
  int             ones_run;
  int             zeros_run;
  logic [NCH-1:0] m_tx;
  bit             m_err;

  task automatic model_reset();
    m_off = 1; m_fault = 0; m_wait = 0; m_act = 0; m_pend = 0;
    ones_run = 0; zeros_run = 0; m_tx = '1; m_err = 0;
  endtask

  task automatic model_step();
    bit             valid;
    bit             stuck;
    bit             quiet;
    logic [NCH-1:0] ntx;
    valid = sel_req && (int'(sel_i) < NCH);
    stuck = zeros_run >= DOM;
    quiet = ones_run >= IDLE;
    ntx   = '1;
    if (m_fault) begin
      if (fault_clr && tx_i) begin m_fault = 0; m_off = !en; end
    end else if (m_off) begin
      if (valid) m_act = int'(sel_i);
      m_off = !en;
    end else if (!en) begin
      m_off = 1; m_wait = 0;
    end else if (stuck) begin
      m_fault = 1; m_wait = 0;
    end else if (m_wait && quiet) begin
      m_act = m_pend; m_wait = 0;
    end else begin
      ntx[m_act] = tx_i;
      if (valid && (m_wait || int'(sel_i) != m_act)) begin
        m_pend = int'(sel_i); m_wait = 1;
      end
    end
    m_tx  = ntx;
    m_err = sel_req && !valid;
    if (tx_i) begin ones_run++; zeros_run = 0; end
    else begin zeros_run++; ones_run = 0; end
  endtask

  // one clock: model advances on the edge, outputs checked 1 time unit later
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("tx_o", 64'(tx_o), 64'(m_tx));
    check("active_sel", 64'(active_sel), 64'(m_act));
    check("busy", 64'(busy), 64'(m_wait));
    check("fault", 64'(fault), 64'(m_fault));
    check("sel_err", 64'(sel_err), 64'(m_err));
  endtask

  // driver: one cycle with the given inputs, request strobes self-clear
  task automatic drive(input bit t, input bit req, input int sel, input bit clr);
    tx_i = t; sel_req = req; sel_i = SW'(sel); fault_clr = clr;
    cycle();
    sel_req = 1'b0; fault_clr = 1'b0;
  endtask

  int  run_left;
  bit  run_val;
  bit  ch5_seen;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_o", 64'(tx_o), 64'hFFFF_FFFF);
    check("rst_active_sel", 64'(active_sel), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_sel_err", 64'(sel_err), 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    rst = 1'b1;
    en  = 1'b1;

    // plain pass-through on channel 0
    for (int i = 0; i < 20; i++) drive(1'($urandom_range(0, 1)), 0, 0, 0);

    // switch to 5 under mixed traffic, then a quiet bus
    drive(1'b0, 1, 5, 0);
    for (int i = 0; i < 30; i++) drive((i % 3) != 0, 0, 0, 0);
    check("busy_before_idle", 64'(busy), 64'd1);
    for (int i = 0; i < 14; i++) drive(1'b1, 0, 0, 0);
    check("switched_to_5", 64'(active_sel), 64'd5);
    for (int i = 0; i < 10; i++) drive(1'($urandom_range(0, 1)), 0, 0, 0);

    // back to 0, then override to 9 while waiting; 5 must never be driven
    drive(1'b1, 1, 0, 0);
    for (int i = 0; i < 40; i++) drive(1'b1, 0, 0, 0);
    drive(1'b0, 1, 5, 0);
    ch5_seen = 0;
    for (int i = 0; i < 12; i++) begin
      drive((i % 2) == 0, (i == 4), 9, 0);
      if (tx_o[5] !== 1'b1) ch5_seen = 1;
    end
    for (int i = 0; i < 16; i++) begin
      drive(1'($urandom_range(0, 1)) | (i > 2), 0, 0, 0);
      if (tx_o[5] !== 1'b1) ch5_seen = 1;
    end
    check("ch5_never_driven", 64'(ch5_seen), 64'd0);
    check("switched_to_9", 64'(active_sel), 64'd9);

    // out-of-range request
    drive(1'b1, 1, 40, 0);
    drive(1'b1, 0, 0, 0);
    check("sel_err_cleared", 64'(sel_err), 64'd0);

    // stuck dominant, clear refused while dominant, then accepted
    for (int i = 0; i < 20; i++) drive(1'b0, 0, 0, 0);
    check("fault_set", 64'(fault), 64'd1);
    drive(1'b0, 0, 0, 1);
    drive(1'b0, 1, 3, 0);
    drive(1'b1, 0, 0, 1);
    check("fault_cleared", 64'(fault), 64'd0);
    for (int i = 0; i < 5; i++) drive(1'($urandom_range(0, 1)), 0, 0, 0);

    // randomized traffic with runs, requests, enable drops and clears
    run_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_left == 0) begin
        run_val  = 1'($urandom_range(0, 1));
        run_left = run_val ? $urandom_range(1, 16) : $urandom_range(1, 20);
      end
      run_left--;
      en = ($urandom_range(0, 99) < 96);
      drive(run_val, ($urandom_range(0, 7) == 0), $urandom_range(0, 40),
            ($urandom_range(0, 3) == 0));
    end
    en = 1'b1;

    // async reset in the middle of a pending switch
    for (int i = 0; i < 3; i++) drive(1'b1, 0, 0, 0);
    drive(1'b0, 1, 7, 0);
    if (m_act == 7) drive(1'b0, 1, 12, 0);
    drive(1'b0, 0, 0, 0);
    check("busy_pre_rst", 64'(busy), 64'(m_wait));
    #2;
    rst = 1'b0;
    #1;
    check("arst_tx_o", 64'(tx_o), 64'hFFFF_FFFF);
    check("arst_active_sel", 64'(active_sel), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    for (int i = 0; i < 16; i++) drive(1'b1, 0, 0, 0);
    check("pending_dropped", 64'(active_sel), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
